ctrl_datagen_alu: RTL and testbench

// - Front end of the Hamming(7,4) transmit/check chain.
// - A phase sequencer steps a 3-bit state Q and drives a one-hot 8-bit timing vector T.
// - T[1] strobes a 4-bit test-data generator; T[2] strobes a Hamming(7,4) encoder (the "ALU").
// - T[3] and T[4] are exported for the downstream error-injection and correction stages.
//

---
 rtl/ctrl_datagen_alu_pkg.sv | 37 +++
 rtl/ctrl_datagen_alu_datagen.sv | 19 +
 rtl/ctrl_datagen_alu_encoder.sv | 24 ++
 rtl/ctrl_datagen_alu_sequencer.sv | 24 ++
 rtl/ctrl_datagen_alu.sv | 37 +++
 tb/tb_ctrl_datagen_alu.sv | 150 +++++++++++++++
 6 files changed

// File: rtl/ctrl_datagen_alu_pkg.sv
// Shared constants, phase encoding and the Hamming(7,4) encode function for
// the transmit/check front end.
package ctrl_datagen_alu_pkg;

  localparam int NUM_PHASES = 8;
  localparam int PH_GEN     = 1;
  localparam int PH_ENC     = 2;
  localparam int PH_ERR     = 3;
  localparam int PH_COR     = 4;
  localparam int DATA_W     = 4;
  localparam int CODE_W     = 7;

  typedef enum logic [2:0] {
    PHASE_IDLE = 3'd0,
    PHASE_GEN  = 3'd1,
    PHASE_ENC  = 3'd2,
    PHASE_ERR  = 3'd3,
    PHASE_COR  = 3'd4,
    PHASE_5    = 3'd5,
    PHASE_6    = 3'd6,
    PHASE_7    = 3'd7
  } phase_e;

  // Bit index 0..6 holds code positions 1..7; parity bits sit at 1, 2 and 4.
  function automatic logic [CODE_W-1:0] hamming74_enc(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c[6] = d[3];
    c[5] = d[2];
    c[4] = d[1];
    c[2] = d[0];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/ctrl_datagen_alu_datagen.sv
// Test-data generator: a 4-bit counter that advances once per frame strobe.
module ctrl_datagen_alu_datagen
  import ctrl_datagen_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data <= data + DATA_W'(1);
    end
  end

endmodule

// File: rtl/ctrl_datagen_alu_encoder.sv
// Hamming(7,4) encoder: combinational encode captured into a register on its strobe.
module hamming74_encoder
  import ctrl_datagen_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  logic [CODE_W-1:0] code_next;

  assign code_next = hamming74_enc(data);

  always_ff @(posedge clk) begin
    if (rst) begin
      code <= '0;
    end else if (en) begin
      code <= code_next;
    end
  end

endmodule

// File: rtl/ctrl_datagen_alu_sequencer.sv
// Phase sequencer: free-running 3-bit phase state plus its one-hot decode.
module ctrl_datagen_alu_sequencer
  import ctrl_datagen_alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic [2:0]            q,
  output logic [NUM_PHASES-1:0] t
);

  phase_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PHASE_IDLE;
    end else begin
      state <= phase_e'(state + 3'd1);
    end
  end

  assign q = state;
  assign t = NUM_PHASES'(1) << state;

endmodule

// File: rtl/ctrl_datagen_alu.sv
// Front end of the Hamming(7,4) chain: phase sequencer, data generator and encoder.
// There is no valid/ready handshake; consumers sample on their own T strobe.
module ctrl_datagen_alu
  import ctrl_datagen_alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic [2:0]            Q,
  output logic [NUM_PHASES-1:0] T,
  output logic [DATA_W-1:0]     data,
  output logic [CODE_W-1:0]     data_out
);

  ctrl_datagen_alu_sequencer u_seq (
    .clk (clk),
    .rst (rst),
    .q   (Q),
    .t   (T)
  );

  ctrl_datagen_alu_datagen u_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (T[PH_GEN]),
    .data (data)
  );

  // Encodes the word the generator produced on the previous phase.
  hamming74_encoder u_enc (
    .clk  (clk),
    .rst  (rst),
    .en   (T[PH_ENC]),
    .data (data),
    .code (data_out)
  );

endmodule

// File: tb/tb_ctrl_datagen_alu.sv
// Self-checking bench for ctrl_datagen_alu against a position-based Hamming model.
module tb_ctrl_datagen_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] q;
  logic [7:0] t;
  logic [3:0] data;
  logic [6:0] data_out;

  int total = 0;
  int bad   = 0;

  int         m_phase = 0;
  int         m_data  = 0;
  logic [6:0] m_code  = '0;
  logic [3:0] exp_q[$];

  ctrl_datagen_alu dut (
    .clk      (clk),
    .rst      (rst),
    .Q        (q),
    .T        (t),
    .data     (data),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Data bits go to positions 3,5,6,7; parity k covers positions whose index has bit k set.
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [7:1] pos;
    int dp[4];
    logic p;
    dp = '{3, 5, 6, 7};
    pos = '0;
    for (int i = 0; i < 4; i++) pos[dp[i]] = d[i];
    for (int k = 1; k <= 4; k = k * 2) begin
      p = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (((j & k) != 0) && (j != k)) p = p ^ pos[j];
      pos[k] = p;
    end
    return pos;
  endfunction

  function automatic int syndrome(input logic [6:0] c);
    int s = 0;
    for (int j = 1; j <= 7; j++)
      if (c[j-1]) s = s ^ j;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare every output mid-cycle.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_data  = 0;
      m_code  = '0;
    end else begin
      if (m_phase == 2) m_code = ref_enc(4'(m_data));
      if (m_phase == 1) m_data = (m_data + 1) % 16;
      m_phase = (m_phase + 1) % 8;
    end
    @(negedge clk);
    chk("q", 8'(q), 8'(m_phase));
    chk("t", t, 8'(1 << m_phase));
    chk("data", 8'(data), 8'(m_data));
    chk("data_out", 8'(data_out), 8'(m_code));
  endtask

  initial begin
    logic [3:0] e;
    bit         hit;
    rst = 1'b1;
    step();
    step();
    chk("reset_q", 8'(q), 8'h00);
    chk("reset_t", t, 8'h01);
    chk("reset_data", 8'(data), 8'h00);
    chk("reset_code", 8'(data_out), 8'h00);

    rst = 1'b0;
    step();
    step();
    chk("first_data", 8'(data), 8'h01);
    step();
    chk("first_code", 8'(data_out), 8'b0000111);
    for (int i = 0; i < 5; i++) step();

    // Expected data across the next 16 frames: 2..F, 0, 1.
    for (int i = 2; i < 18; i++) exp_q.push_back(4'(i));
    for (int f = 0; f < 16; f++) begin
      for (int s = 0; s < 8; s++) begin
        step();
        if (q == 3'd3 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wrap_data", 8'(data), 8'(e));
          chk("roundtrip", 8'({data_out[6], data_out[5], data_out[4], data_out[2]}), 8'(e));
          chk("syndrome", 8'(syndrome(data_out)), 8'h00);
          case (e)
            4'hB: chk("vec_b", 8'(data_out), 8'b1010101);
            4'hF: chk("vec_f", 8'(data_out), 8'b1111111);
            4'h0: chk("vec_0", 8'(data_out), 8'b0000000);
            4'h8: chk("vec_8", 8'(data_out), 8'b1001011);
            default: ;
          endcase
        end
      end
    end
    chk("wrap_all_seen", 8'(exp_q.size()), 8'h00);

    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      step();
      if (q == 3'd5) hit = 1'b1;
    end
    chk("reach_q5", 8'(hit), 8'h01);
    rst = 1'b1;
    step();
    chk("mid_rst_q", 8'(q), 8'h00);
    chk("mid_rst_data", 8'(data), 8'h00);
    chk("mid_rst_code", 8'(data_out), 8'h00);
    rst = 1'b0;
    step();
    chk("restart_q", 8'(q), 8'h01);
    step();
    chk("restart_data", 8'(data), 8'h01);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
